// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: runs a WIDTH-bit AND/OR/ADD/SUB one bit per clock, LSB first,
// through an external 1-bit ALU slice, chaining the slice's Cout back into Cin.
module bit_serial_alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic [1:0]       alu_sel,
    input  logic             alu_result,
    input  logic             alu_cout
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [1:0]       op_q;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             run;

    assign run     = state == RUN;
    assign alu_a   = run & a_sh[0];
    assign alu_b   = run & b_sh[0];
    assign alu_cin = run & carry;
    assign alu_sel = run ? op_q : 2'b00;

    // result doubles as the result shift register: each slice bit enters at the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            op_q      <= 2'b00;
            carry     <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            carry_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sh  <= a;
                    b_sh  <= b;
                    op_q  <= op;
                    carry <= 1'b0;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    state <= RUN;
                end
                RUN: begin
                    result <= {alu_result, result[WIDTH-1:1]};
                    carry  <= alu_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        carry_out <= alu_cout;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/bit_serial_alu_seq.md
Name: bit_serial_alu_seq

Overview:
- Sequencer that runs a WIDTH-bit operation through the team's external 1-bit ALU slice, one bit per clock, LSB first.
- Chains the slice's Cout back into Cin on the next bit.
- Sits between a requester (start/done handshake) and one 1-bit ALU slice instance. It owns operand shifting, carry/borrow chaining and result assembly.

Parameters:
- WIDTH, 8, operand/result width in bits (legal: WIDTH >= 2).
- CNT_W, $clog2(WIDTH)+1, bit-counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 AND, 01 OR, 10 ADD, 11 SUB.
- a  input  WIDTH  operand A; latched on accept.
- b  input  WIDTH  operand B; latched on accept.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; result valid.
- result  output  WIDTH  assembled result; held until next accept.
- carry_out  output  1  final Cout of the chain (carry for ADD, borrow for SUB, 0 for AND/OR).
- alu_a  output  1  to slice A.
- alu_b  output  1  to slice B.
- alu_cin  output  1  to slice Cin.
- alu_sel  output  2  to slice sel.
- alu_result  input  1  from slice Result (combinational).
- alu_cout  input  1  from slice Cout (combinational).

Behaviour:
- Slice contract: AND/OR give Cout=0. ADD gives {Cout,R}=A+B+Cin. SUB gives {Cout,R}=A-B-Cin, so Cout=1 means borrow.
- Reset (rst_n low, asynchronous): state IDLE; busy=0, done=0, result=0, carry_out=0; internal shift registers, carry and counter cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN when start=1 at edge k:
  - a, b, op latched into a_sh, b_sh, op_q.
  - carry register cleared to 0, counter cleared to 0.
- RUN, combinational slice drive: alu_a=a_sh[0], alu_b=b_sh[0], alu_cin=carry, alu_sel=op_q.
- RUN, on each edge:
  - Capture alu_result into the result shift register (shift right, insert at MSB).
  - carry <= alu_cout.
  - a_sh, b_sh shift right.
  - Counter increments.
- Bit i is captured at edge k+1+i.
- RUN -> DONE at the edge that captures bit WIDTH-1 (edge k+WIDTH). On that same edge carry_out takes alu_cout.
- DONE: done=1 for exactly one cycle, busy=0. Next edge goes to IDLE.
- Latency: done is high in the cycle that starts WIDTH cycles after the accepting edge. Minimum request-to-request spacing is WIDTH+2 cycles.
- Outside RUN, alu_a, alu_b, alu_cin and alu_sel are all 0.
- result and carry_out are registered and stable from DONE until the next accept. During RUN they update only internally: result is the shift register and is not guaranteed meaningful before done.
- start while in RUN or DONE is ignored and not queued. start held high continuously is re-accepted in the first IDLE cycle.
- a, b and op changing after accept have no effect on the running operation.
- Arithmetic is modulo 2^WIDTH. SUB result is (a-b) mod 2^WIDTH; carry_out=1 iff a<b.
- Reset asserted mid-RUN aborts immediately: no done pulse, result and carry_out cleared. First accept is possible on the first edge after rst_n deasserts.

Test Plan (WIDTH=8, bench instantiates the team's 1-bit ALU slice on the alu_* ports):
1. ADD a=0xFF, b=0x01, start pulse at edge k -> busy high for 8 cycles, done pulse exactly at cycle k+8, result=0x00, carry_out=1. Then ADD 0x3A+0x45 -> 0x7F, carry_out=0.
2. SUB a=0x05, b=0x07 -> result=0xFE, carry_out=1. SUB a=0x10, b=0x01 -> result=0x0F, carry_out=0. SUB a=b=0x80 -> 0x00, carry_out=0.
3. AND a=0xF0, b=0x3C -> 0x30, carry_out=0. OR same operands -> 0xFC, carry_out=0. Check alu_sel equals op throughout RUN and alu_* are 0 in IDLE.
4. Start ADD 0x01+0x01, then pulse start with op=SUB a=0xAA b=0x55 at the 3rd RUN cycle and in DONE -> both ignored. Result=0x02, exactly one done pulse. Then verify a later accept works.
5. Start ADD 0xFF+0xFF, assert rst_n=0 asynchronously mid-cycle at the 4th RUN cycle -> busy, done, result, carry_out go 0 immediately with no done pulse. After release, ADD 0x12+0x34 -> 0x46.
6. Hold start=1 with random a, b, op for 200 back-to-back operations -> each result and carry_out matches the reference model ({carry,result} of a+b / a-b, AND/OR with carry 0). Spacing between done pulses is exactly 10 cycles.
